nvdla_glb_intr_agg: RTL and testbench
=====================================

// Module: nvdla_glb_intr_agg
// PURPOSE
//  Parametrised global interrupt aggregator with CSB register access; successor to the fixed 6-unit glb block.
//  Collects NUM_SRC x NUM_GRP done pulses into sticky status bits, applies per-bit masks and drives one core_intr.
//  Adds software set and a pending view; optional interrupt coalescing. Sits between unit done pulses and host CSB.
// PARAMETERS
//  NUM_SRC   6   number of interrupting units (sdp, cdp, pdp, cdma_wt, cdma_dat, cacc order by default)
//  NUM_GRP   2   register groups (ping-pong) per unit; NB = NUM_SRC*NUM_GRP, legal range 1..32
//  TMO_W     16  width of coalescing timeout counter (used only with macro)
// PORTS
//  nvdla_core_clk     in  1   sole clock
//  nvdla_core_rst     in  1   reset, synchronous, active-high
//  csb_req_pvld       in  1   request valid
//  csb_req_prdy       out 1   request ready
//  csb_req_addr       in  4   register word offset
//  csb_req_wdat       in  32  write data
//  csb_req_write      in  1   1=write, 0=read
//  csb_req_nposted    in  1   write requires ack
//  csb_resp_valid     out 1   response valid, single cycle, no backpressure
//  csb_resp_pd        out 34  [33]=1 write ack / 0 read data, [32]=error, [31:0]=rdata (0 for acks)
//  done_intr_pd       in  NB  done pulses, bit src*NUM_GRP+grp, one-cycle pulse per event
//  core_intr          out 1   level interrupt to host
// BEHAVIOUR
//  - Reset: status=0, mask=all ones (masked), resp_valid=0, resp_pd=0, core_intr=0, prdy=0 during reset, 1 after.
//  - Accept = pvld & prdy; prdy=1 every cycle out of reset (one request per cycle, no stall).
//  - Response registered: resp_valid exactly 1 cycle after accept for reads and non-posted writes; posted writes give none.
//  - Register map (word offset): 0 STATUS R/W1C; 1 MASK R/W (1=masked); 2 SET W1S into STATUS, reads 0;
//    3 PENDING RO = STATUS & ~MASK; 4 COAL_CFG (macro only). Other offsets, or 4 without macro: read returns 0, error=1;
//    write ignored, ack error=1. Write to RO PENDING: ignored, error=1. Bits [31:NB] read 0, writes ignored.
//  - status_nxt = (status & ~w1c) | w1s | done_intr_pd; same-cycle hw pulse and W1C on one bit -> bit stays 1.
//  - Read of STATUS returns value before that cycle's update (pre-update register value).
//  - Without macro: core_intr registered = |(status & ~mask); 1 cycle from status change to core_intr change.
//  - Mask change takes effect on core_intr next cycle; masking does not clear status.
//  - Reset mid-transaction: accepted request dropped, no response issued.
// CONFIGURATION
//  NVDLA_GLB_INTR_COAL_EN defined: COAL_CFG [7:0]=count threshold THR, [8+TMO_W-1:8]=timeout TMO; reset 0.
//   FSM IDLE->ACCUM when pending!=0; ACCUM->FIRE when popcount(pending)>=THR or timer==TMO (timer counts from ACCUM entry);
//   FIRE holds core_intr=1 until pending==0 -> IDLE. THR<=1 or TMO==0: ACCUM->FIRE in 1 cycle (immediate).
//   Pending drops to 0 while in ACCUM -> IDLE, timer cleared, no interrupt.
//  Undefined: no FSM, no COAL_CFG register, core_intr as above.
// STRUCTURE
//  Package nvdla_glb_intr_pkg: register offset constants, resp_pd field positions, coal FSM state enum, COAL_CFG field widths.
//  Sub-module nvdla_glb_intr_coal: coalescing FSM + timer + popcount (instantiated only under macro).
// TESTING
//  Reset, read MASK -> resp 1 cycle later, pd={0,0,0x00000FFF} (NB=12); core_intr=0.
//  Write MASK=0, pulse done bit 4 -> STATUS reads 0x010, core_intr=1 two cycles after pulse; W1C 0x010 -> core_intr=0.
//  Pulse bit 2 same cycle as W1C of bit 2 -> STATUS bit 2 remains 1, core_intr stays 1.
//  SET write 0x800 non-posted -> ack pd={1,0,0}; PENDING reads 0x800; posted write to offset 9 -> no response.
//  Read offset 9 -> pd={0,1,0}; write PENDING -> ack error=1, value unchanged.
//  Macro: THR=3, TMO=20, mask 0; pulse 2 bits -> core_intr asserts 20 cycles after ACCUM entry; 3 bits -> within 2 cycles.

Source files
------------

// File: rtl/nvdla_glb_intr_pkg.sv
// rtl/nvdla_glb_intr_pkg.sv - register map, response fields and coalescing types for the global interrupt aggregator
package nvdla_glb_intr_pkg;

  localparam int CSB_AW = 4;

  localparam logic [CSB_AW-1:0] REG_STATUS   = 4'd0;
  localparam logic [CSB_AW-1:0] REG_MASK     = 4'd1;
  localparam logic [CSB_AW-1:0] REG_SET      = 4'd2;
  localparam logic [CSB_AW-1:0] REG_PENDING  = 4'd3;
  localparam logic [CSB_AW-1:0] REG_COAL_CFG = 4'd4;

  localparam int RESP_W       = 34;
  localparam int RESP_ACK_BIT = 33;
  localparam int RESP_ERR_BIT = 32;

  localparam int COAL_THR_W   = 8;
  localparam int COAL_TMO_LSB = 8;

  typedef enum logic [1:0] {
    COAL_IDLE  = 2'd0,
    COAL_ACCUM = 2'd1,
    COAL_FIRE  = 2'd2
  } coal_state_e;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + 6'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/nvdla_glb_intr_coal.sv
// rtl/nvdla_glb_intr_coal.sv - coalescing FSM: holds off core_intr until enough pending bits or a timeout
module nvdla_glb_intr_coal
  import nvdla_glb_intr_pkg::*;
#(
  parameter int NB    = 12,
  parameter int TMO_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NB-1:0]         pending,
  input  logic [COAL_THR_W-1:0] thr,
  input  logic [TMO_W-1:0]      tmo,
  output logic                  core_intr
);

  coal_state_e      state, state_nxt;
  logic [TMO_W-1:0] timer, timer_nxt;
  logic [5:0]       pend_cnt;
  logic             any_pend;
  logic             fire_now;

  assign any_pend = |pending;
  assign pend_cnt = popcount32(32'(pending));
  assign fire_now = (thr <= 8'd1) || (tmo == '0) ||
                    ({2'b00, pend_cnt} >= thr) || (timer >= tmo);

  // timer holds the number of cycles spent in ACCUM, including the current one
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    case (state)
      COAL_IDLE: begin
        if (any_pend) begin
          state_nxt = COAL_ACCUM;
          timer_nxt = TMO_W'(1);
        end
      end
      COAL_ACCUM: begin
        if (!any_pend) begin
          state_nxt = COAL_IDLE;
          timer_nxt = '0;
        end else if (fire_now) begin
          state_nxt = COAL_FIRE;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + TMO_W'(1);
        end
      end
      COAL_FIRE: begin
        if (!any_pend) state_nxt = COAL_IDLE;
      end
      default: begin
        state_nxt = COAL_IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COAL_IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  assign core_intr = (state == COAL_FIRE);

endmodule

// File: rtl/nvdla_glb_intr_agg.sv
// rtl/nvdla_glb_intr_agg.sv - sticky done-pulse status with CSB access; NVDLA_GLB_INTR_COAL_EN adds coalescing
module nvdla_glb_intr_agg
  import nvdla_glb_intr_pkg::*;
#(
  parameter int NUM_SRC = 6,
  parameter int NUM_GRP = 2,
  parameter int TMO_W   = 16
) (
  input  logic                        nvdla_core_clk,
  input  logic                        nvdla_core_rst,
  input  logic                        csb_req_pvld,
  output logic                        csb_req_prdy,
  input  logic [CSB_AW-1:0]           csb_req_addr,
  input  logic [31:0]                 csb_req_wdat,
  input  logic                        csb_req_write,
  input  logic                        csb_req_nposted,
  output logic                        csb_resp_valid,
  output logic [RESP_W-1:0]           csb_resp_pd,
  input  logic [NUM_SRC*NUM_GRP-1:0]  done_intr_pd,
  output logic                        core_intr
);

  localparam int NB = NUM_SRC * NUM_GRP;

  logic          accept, wr;
  logic [NB-1:0] status, mask, pending, w1c, w1s, wbits;
  logic          mask_we, err;
  logic [31:0]   rdata;
  logic          unused_sink;

  assign csb_req_prdy = ~nvdla_core_rst;
  assign accept       = csb_req_pvld & csb_req_prdy;
  assign wr           = accept & csb_req_write;
  assign wbits        = csb_req_wdat[NB-1:0];
  assign pending      = status & ~mask;
  assign unused_sink  = ^{csb_req_wdat, TMO_W[0]};

`ifdef NVDLA_GLB_INTR_COAL_EN
  logic [COAL_TMO_LSB+TMO_W-1:0] coal_cfg;
  logic                          cfg_we;
`endif

  always_comb begin
    rdata   = '0;
    err     = 1'b0;
    w1c     = '0;
    w1s     = '0;
    mask_we = 1'b0;
`ifdef NVDLA_GLB_INTR_COAL_EN
    cfg_we  = 1'b0;
`endif
    case (csb_req_addr)
      REG_STATUS: begin
        rdata = 32'(status);
        if (wr) w1c = wbits;
      end
      REG_MASK: begin
        rdata   = 32'(mask);
        mask_we = wr;
      end
      REG_SET: begin
        if (wr) w1s = wbits;
      end
      REG_PENDING: begin
        rdata = 32'(pending);
        err   = csb_req_write;
      end
`ifdef NVDLA_GLB_INTR_COAL_EN
      REG_COAL_CFG: begin
        rdata  = 32'(coal_cfg);
        cfg_we = wr;
      end
`endif
      default: err = 1'b1;
    endcase
  end

  // hardware pulses win over a same-cycle W1C on the same bit
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      status         <= '0;
      mask           <= '1;
      csb_resp_valid <= 1'b0;
      csb_resp_pd    <= '0;
    end else begin
      status <= (status & ~w1c) | w1s | done_intr_pd;
      if (mask_we) mask <= wbits;
      csb_resp_valid <= accept & (~csb_req_write | csb_req_nposted);
      if (accept & (~csb_req_write | csb_req_nposted))
        csb_resp_pd <= {csb_req_write, err, csb_req_write ? 32'd0 : rdata};
    end
  end

`ifdef NVDLA_GLB_INTR_COAL_EN
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) coal_cfg <= '0;
    else if (cfg_we)    coal_cfg <= csb_req_wdat[COAL_TMO_LSB+TMO_W-1:0];
  end

  nvdla_glb_intr_coal #(
    .NB    (NB),
    .TMO_W (TMO_W)
  ) u_coal (
    .clk       (nvdla_core_clk),
    .rst       (nvdla_core_rst),
    .pending   (pending),
    .thr       (coal_cfg[COAL_THR_W-1:0]),
    .tmo       (coal_cfg[COAL_TMO_LSB+TMO_W-1:COAL_TMO_LSB]),
    .core_intr (core_intr)
  );
`else
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) core_intr <= 1'b0;
    else                core_intr <= |pending;
  end
`endif

endmodule

// File: tb/tb_nvdla_glb_intr_agg.sv
// tb/tb_nvdla_glb_intr_agg.sv - randomized bench with behavioural register model for nvdla_glb_intr_agg
module tb_nvdla_glb_intr_agg;

  localparam int NB = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pvld = 1'b0, prdy, write = 1'b0, nposted = 1'b0;
  logic [3:0]    addr = '0;
  logic [31:0]   wdat = '0;
  logic          rv;
  logic [33:0]   pd;
  logic [NB-1:0] done = '0;
  logic          intr;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  always #5 clk = ~clk;

  nvdla_glb_intr_agg #(.NUM_SRC(6), .NUM_GRP(2), .TMO_W(16)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rst  (rst),
    .csb_req_pvld    (pvld),
    .csb_req_prdy    (prdy),
    .csb_req_addr    (addr),
    .csb_req_wdat    (wdat),
    .csb_req_write   (write),
    .csb_req_nposted (nposted),
    .csb_resp_valid  (rv),
    .csb_resp_pd     (pd),
    .done_intr_pd    (done),
    .core_intr       (intr)
  );

  function automatic void chk(input string name, input logic [33:0] got, input logic [33:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endfunction

  // Reference model: what each register must hold, and what each response must carry
  logic [NB-1:0] m_status, m_mask, mw1c, mw1s;
  logic          m_intr, m_rv, acc;
  logic [33:0]   m_pd;

  function automatic logic [33:0] model_resp(input logic [3:0] a, input logic w,
                                             input logic [NB-1:0] st, input logic [NB-1:0] mk);
    logic        e;
    logic [31:0] d;
    e = !(a inside {4'd0, 4'd1, 4'd2, 4'd3}) || (w && a == 4'd3);
    case (a)
      4'd0:    d = 32'(st);
      4'd1:    d = 32'(mk);
      4'd3:    d = 32'(st & ~mk);
      default: d = 32'd0;
    endcase
    return {w, e, w ? 32'd0 : d};
  endfunction

  always_comb begin
    mw1c = '0;
    mw1s = '0;
    acc  = pvld && !rst;
    if (acc && write && addr == 4'd0) mw1c = wdat[NB-1:0];
    if (acc && write && addr == 4'd2) mw1s = wdat[NB-1:0];
  end

  always @(posedge clk) begin
    if (rst) begin
      m_status <= '0;
      m_mask   <= '1;
      m_intr   <= 1'b0;
      m_rv     <= 1'b0;
      m_pd     <= '0;
    end else begin
      m_status <= (m_status & ~mw1c) | mw1s | done;
      if (acc && write && addr == 4'd1) m_mask <= wdat[NB-1:0];
      m_intr <= |(m_status & ~m_mask);
      m_rv   <= acc && (!write || nposted);
      m_pd   <= model_resp(addr, write, m_status, m_mask);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("prdy", 34'(prdy), 34'(!rst));
      chk("resp_valid", 34'(rv), 34'(m_rv));
      if (m_rv) chk("resp_pd", pd, m_pd);
`ifndef NVDLA_GLB_INTR_COAL_EN
      chk("core_intr", 34'(intr), 34'(m_intr));
`endif
    end
  end

  // Issue one request at a negedge; on return the response (if any) is visible
  task automatic csb(input logic [3:0] a, input logic [31:0] d, input logic w, input logic np);
    pvld = 1'b1; addr = a; wdat = d; write = w; nposted = np;
    @(negedge clk);
    pvld = 1'b0; write = 1'b0; nposted = 1'b0;
  endtask

  task automatic pulse(input logic [NB-1:0] v);
    done = v;
    @(negedge clk);
    done = '0;
  endtask

  logic [3:0] addr_tbl [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd9, 4'd15};

  initial begin
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_prdy", 34'(prdy), 34'd0);
    chk("rst_intr", 34'(intr), 34'd0);
    chk("rst_rv",   34'(rv),   34'd0);
    rst = 1'b0;
    @(negedge clk);

    csb(4'd1, 32'd0, 1'b0, 1'b0);
    chk("mask_rst_valid", 34'(rv), 34'd1);
    chk("mask_rst_pd", pd, 34'h0_0000_0FFF);
    csb(4'd1, 32'd0, 1'b1, 1'b0);

    pulse(12'h010);
    chk("intr_lag", 34'(intr), 34'd0);
    csb(4'd0, 32'd0, 1'b0, 1'b0);
    chk("status_b4", pd, 34'h0_0000_0010);
    chk("intr_2cyc", 34'(intr), 34'd1);
    csb(4'd0, 32'h10, 1'b1, 1'b1);
    chk("w1c_ack", pd, 34'h2_0000_0000);
    @(negedge clk);
    chk("intr_clr", 34'(intr), 34'd0);

    pulse(12'h004);
    @(negedge clk);
    done = 12'h004;
    csb(4'd0, 32'h4, 1'b1, 1'b0);
    done = '0;
    csb(4'd0, 32'd0, 1'b0, 1'b0);
    chk("race_status", pd, 34'h0_0000_0004);
    chk("race_intr", 34'(intr), 34'd1);
    csb(4'd0, 32'h4, 1'b1, 1'b0);

    csb(4'd2, 32'h800, 1'b1, 1'b1);
    chk("set_ack", pd, 34'h2_0000_0000);
    csb(4'd3, 32'd0, 1'b0, 1'b0);
    chk("pending_rd", pd, 34'h0_0000_0800);
    csb(4'd9, 32'h1234, 1'b1, 1'b0);
    chk("posted_bad_noresp", 34'(rv), 34'd0);
    csb(4'd9, 32'd0, 1'b0, 1'b0);
    chk("bad_rd", pd, 34'h1_0000_0000);
    csb(4'd3, 32'hFFF, 1'b1, 1'b1);
    chk("pending_wr_err", pd, 34'h3_0000_0000);
    csb(4'd3, 32'd0, 1'b0, 1'b0);
    chk("pending_keep", pd, 34'h0_0000_0800);
`ifndef NVDLA_GLB_INTR_COAL_EN
    csb(4'd4, 32'd0, 1'b0, 1'b0);
    chk("coal_absent", pd, 34'h1_0000_0000);
`endif
    csb(4'd0, 32'hFFF, 1'b1, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      pvld    = ($urandom_range(0, 2) != 0);
      addr    = addr_tbl[$urandom_range(0, 5)];
      write   = $urandom_range(0, 1);
      nposted = $urandom_range(0, 1);
      wdat    = $urandom;
      if (addr == 4'd1 && $urandom_range(0, 1) == 0) wdat = wdat & 32'h0000_0F0F;
      done    = ($urandom_range(0, 3) == 0) ? NB'(1 << $urandom_range(0, NB - 1)) : '0;
      rst     = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    pvld = 1'b0; write = 1'b0; done = '0; rst = 1'b0;
    @(negedge clk);

`ifdef NVDLA_GLB_INTR_COAL_EN
    begin
      int c;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      csb(4'd4, (32'd20 << 8) | 32'd3, 1'b1, 1'b0);
      csb(4'd1, 32'd0, 1'b1, 1'b0);
      pulse(12'h003);
      c = 1;
      while (!intr && c < 100) begin
        @(negedge clk);
        c++;
      end
      chk("coal_tmo", 34'(c), 34'd22);
      csb(4'd0, 32'hFFF, 1'b1, 1'b0);
      c = 0;
      while (intr && c < 10) begin
        @(negedge clk);
        c++;
      end
      chk("coal_drop", 34'(intr), 34'd0);
      pulse(12'h007);
      c = 1;
      while (!intr && c < 100) begin
        @(negedge clk);
        c++;
      end
      chk("coal_thr", 34'(c), 34'd3);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
